// File: rtl/dff_edge_logger.sv
// dff_edge_logger: watches a single-bit dff output q, stamps every transition
// with a free-running cycle counter and queues {level, ts} events in a
// show-ahead FIFO that a consumer drains over a valid/ready port.
module dff_edge_logger #(
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     q,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic                     ev_level,
    output logic [TS_W-1:0]          ev_ts,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [TS_W-1:0]  ts;
    logic             q_prev;
    logic [DEPTH-1:0] lvl_mem;
    logic [TS_W-1:0]  ts_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic edge_det;
    logic full;
    logic push;
    logic pop;
    logic wr;
    logic drop;

    // Control decode; clr masks both push and pop so it wins outright.
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign edge_det = q ^ q_prev;
    assign full     = (count == FULL_CNT);
    assign push     = edge_det & en & ~clr;
    assign pop      = ev_valid & ev_ready & ~clr;
    assign wr       = push & (~full | pop);
    assign drop     = push & full & ~pop;

    // Outputs come straight from registers: no path from q or ev_ready.
    assign ev_valid = (count != '0);
    assign ev_count = count;
    assign ev_level = lvl_mem[rd_ptr];
    assign ev_ts    = ts_mem[rd_ptr];

    // Free-running timestamp and previous-q tracker; clr restarts ts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts     <= '0;
            q_prev <= 1'b0;
        end else begin
            q_prev <= q;
            if (clr) ts <= '0;
            else     ts <= ts + 1'b1;
        end
    end

    // Event storage; cleared on reset so the head reads 0 while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_mem <= '0;
            for (int i = 0; i < DEPTH; i++) ts_mem[i] <= '0;
        end else if (wr) begin
            lvl_mem[wr_ptr] <= q;
            ts_mem[wr_ptr]  <= ts;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Lost-edge bookkeeping: sticky flag plus saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dff_edge_logger.sv
// Bench for dff_edge_logger: directed steps followed by a random phase, all
// checked against a queue-based event model updated once per clock.
module tb_dff_edge_logger;

    localparam int TS_W   = 4;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 3;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              clr = 1'b0;
    logic              q = 1'b0;
    logic              ev_ready = 1'b0;
    logic              ev_valid;
    logic              ev_level;
    logic [TS_W-1:0]   ev_ts;
    logic [CW-1:0]     ev_count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    dff_edge_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .q(q),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_level(ev_level),
        .ev_ts(ev_ts), .ev_count(ev_count), .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state: queue entries are {level, ts}.
    int            mts;
    logic          mqp;
    logic [TS_W:0] mq[$];
    logic          mov;
    int            mdrop;
    int            ncmp = 0;
    int            nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mts = 0; mqp = 1'b0; mq.delete(); mov = 1'b0; mdrop = 0;
    endtask

    // One clock of the model, from the inputs held across the edge.
    task automatic model_step();
        logic [TS_W:0] e;
        if (!rst_n) return;
        if (clr) begin
            mq.delete(); mts = 0; mov = 1'b0; mdrop = 0; mqp = q;
            return;
        end
        e = {q, 4'(mts)};
        if (mq.size() > 0 && ev_ready) void'(mq.pop_front());
        if (q !== mqp && en) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else begin
                mov = 1'b1;
                if (mdrop < (1 << DROP_W) - 1) mdrop++;
            end
        end
        mqp = q;
        mts = (mts + 1) % (1 << TS_W);
    endtask

    task automatic check_all(input string tag);
        logic [TS_W:0] h;
        chk({tag, ".valid"}, 32'(ev_valid), 32'(mq.size() > 0));
        chk({tag, ".count"}, 32'(ev_count), 32'(mq.size()));
        chk({tag, ".ovf"},   32'(overflow), 32'(mov));
        chk({tag, ".drop"},  32'(drop_cnt), 32'(mdrop));
        if (mq.size() > 0) begin
            h = mq[0];
            chk({tag, ".level"}, 32'(ev_level), 32'(h[TS_W]));
            chk({tag, ".ts"},    32'(ev_ts),    32'(h[TS_W-1:0]));
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic toggles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            q = ~q;
            cyc(tag);
        end
    endtask

    initial begin
        // Reset state
        model_reset();
        #2;
        chk("rst.valid", 32'(ev_valid), 0);
        chk("rst.count", 32'(ev_count), 0);
        chk("rst.level", 32'(ev_level), 0);
        chk("rst.ts",    32'(ev_ts), 0);
        chk("rst.ovf",   32'(overflow), 0);
        chk("rst.drop",  32'(drop_cnt), 0);
        #10 rst_n = 1'b1;   // released just after a falling edge
        en = 1'b1;

        // 1: rising edge at ts=5, visible next cycle
        repeat (5) cyc("t1.idle");
        q = 1'b1;
        cyc("t1.edge");
        chk("t1.valid", 32'(ev_valid), 1);
        chk("t1.level", 32'(ev_level), 1);
        chk("t1.ts",    32'(ev_ts), 5);
        chk("t1.count", 32'(ev_count), 1);
        ev_ready = 1'b1;
        cyc("t1.pop");
        ev_ready = 1'b0;

        // 2: nine toggles into an 8-deep FIFO, then drain in order
        toggles(9, "t2.fill");
        chk("t2.count", 32'(ev_count), 8);
        chk("t2.ovf",   32'(overflow), 1);
        chk("t2.drop",  32'(drop_cnt), 1);
        ev_ready = 1'b1;
        repeat (8) cyc("t2.drain");
        chk("t2.empty", 32'(ev_valid), 0);
        ev_ready = 1'b0;

        // 3: full FIFO, edge and pop together
        toggles(8, "t3.fill");
        ev_ready = 1'b1;
        q = ~q;
        cyc("t3.pushpop");
        chk("t3.count", 32'(ev_count), 8);
        chk("t3.drop",  32'(drop_cnt), 1);
        ev_ready = 1'b0;

        // Drop counter saturation
        toggles(12, "sat");
        chk("sat.drop", 32'(drop_cnt), 7);

        // 5: clr with an edge in the clr cycle, then a fresh timestamp base
        clr = 1'b1; q = ~q;
        cyc("t5.clr");
        clr = 1'b0;
        chk("t5.valid", 32'(ev_valid), 0);
        chk("t5.count", 32'(ev_count), 0);
        chk("t5.ovf",   32'(overflow), 0);
        chk("t5.drop",  32'(drop_cnt), 0);
        repeat (3) cyc("t5.idle");
        q = ~q;
        cyc("t5.edge");
        chk("t5.ts", 32'(ev_ts), 3);
        ev_ready = 1'b1;
        cyc("t5.pop");
        ev_ready = 1'b0;

        // 4: timestamp wrap 15 -> 1
        for (int i = 0; i < 20 && mts != 15; i++) cyc("t4.seek");
        q = ~q; cyc("t4.e1");
        cyc("t4.gap");
        q = ~q; cyc("t4.e2");
        chk("t4.ts15", 32'(ev_ts), 15);
        ev_ready = 1'b1;
        cyc("t4.pop");
        chk("t4.ts1", 32'(ev_ts), 1);
        cyc("t4.pop2");
        ev_ready = 1'b0;

        // 6: en=0 discards edges without counting drops
        en = 1'b0;
        toggles(4, "t6.dis");
        chk("t6.count", 32'(ev_count), 0);
        chk("t6.drop",  32'(drop_cnt), 0);
        en = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            q        = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 7) != 0);
            ev_ready = 1'($urandom_range(0, 1));
            clr      = ($urandom_range(0, 39) == 0);
            cyc("rnd");
        end
        clr = 1'b0; en = 1'b1; ev_ready = 1'b0;

        // Async reset in the middle of a drain
        toggles(4, "mid.fill");
        ev_ready = 1'b1;
        cyc("mid.drain");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid.valid", 32'(ev_valid), 0);
        chk("mid.count", 32'(ev_count), 0);
        chk("mid.level", 32'(ev_level), 0);
        chk("mid.ts",    32'(ev_ts), 0);
        chk("mid.ovf",   32'(overflow), 0);
        chk("mid.drop",  32'(drop_cnt), 0);
        q = 1'b0; ev_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q = 1'b1;
        cyc("post.edge");
        chk("post.ts", 32'(ev_ts), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
